// File: rtl/mem_port_master.sv
// mem_port_master: req/gnt/rvalid memory-port initiator with credit-limited in-order responses
module mem_port_master #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic                    cmd_we_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_we_o,
  output logic                    data_req_o,
  input  logic                    data_gnt_i,
  input  logic                    data_rvalid_i,
  output logic [ADDR_WIDTH-1:0]   data_addr_o,
  output logic                    data_we_o,
  output logic [DATA_WIDTH/8-1:0] data_be_o,
  output logic [DATA_WIDTH-1:0]   data_wdata_o,
  input  logic [DATA_WIDTH-1:0]   data_rdata_i,
  output logic                    busy_o
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 2;
  logic                  req_valid;
  logic [CW-1:0]         outstanding, rsp_count, inflight;
  logic [PW-1:0]         tag_wr, tag_rd, rsp_wr, rsp_rd;
  logic                  tag_mem [MAX_OUTSTANDING];
  logic [DATA_WIDTH:0]   rsp_mem [MAX_OUTSTANDING];
  logic                  cmd_fire, gnt_fire, rv_fire, rsp_fire, rv_we;
  assign inflight    = CW'(req_valid) + outstanding + rsp_count;
  assign cmd_ready_o = (inflight < CW'(MAX_OUTSTANDING)) && (!req_valid || data_gnt_i);
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign gnt_fire    = req_valid && data_gnt_i;
  assign rv_fire     = data_rvalid_i && (outstanding != '0);
  assign rsp_valid_o = rsp_count != '0;
  assign rsp_fire    = rsp_valid_o && rsp_ready_i;
  assign rv_we       = tag_mem[tag_rd];
  assign rsp_we_o    = rsp_valid_o && rsp_mem[rsp_rd][DATA_WIDTH];
  assign rsp_rdata_o = rsp_valid_o ? rsp_mem[rsp_rd][DATA_WIDTH-1:0] : '0;
  assign data_req_o  = req_valid;
  assign busy_o      = inflight != '0;
  // request register: load on command handshake, clear on grant, fields hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid    <= 1'b0;
      data_addr_o  <= '0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_wdata_o <= '0;
    end else if (cmd_fire) begin
      req_valid    <= 1'b1;
      data_addr_o  <= cmd_addr_i;
      data_we_o    <= cmd_we_i;
      data_be_o    <= cmd_be_i;
      data_wdata_o <= cmd_wdata_i;
    end else if (gnt_fire) begin
      req_valid    <= 1'b0;
    end
  end
  // occupancy counters and FIFO pointers; spurious rvalid is filtered by rv_fire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      rsp_count   <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      rsp_wr      <= '0;
      rsp_rd      <= '0;
    end else begin
      outstanding <= outstanding + CW'(gnt_fire) - CW'(rv_fire);
      rsp_count   <= rsp_count + CW'(rv_fire) - CW'(rsp_fire);
      tag_wr      <= tag_wr + PW'(gnt_fire);
      tag_rd      <= tag_rd + PW'(rv_fire);
      rsp_wr      <= rsp_wr + PW'(rv_fire);
      rsp_rd      <= rsp_rd + PW'(rsp_fire);
    end
  end
  // tag and response storage; contents are only observed through valid pointers
  always_ff @(posedge clk) begin
    if (gnt_fire) tag_mem[tag_wr] <= data_we_o;
    if (rv_fire) rsp_mem[rsp_wr] <= {rv_we, rv_we ? {DATA_WIDTH{1'b0}} : data_rdata_i};
  end
  spurious_rvalid: assert property (@(posedge clk) disable iff (!rst_n) data_rvalid_i |-> outstanding != '0)
    else $warning("data_rvalid_i with nothing outstanding, ignored");
endmodule
